// File: rtl/mem_stage_rv32.sv
// RV32I memory stage: issues word-bus load/store requests, aligns and extends load data,
// and passes non-memory results to writeback. Optional bus timeout: define MEM_TIMEOUT_EN.
module mem_stage_rv32 #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iRW,
    input  logic        iMEM,
    input  logic [31:0] iMEMADDR,
    input  logic [31:0] iMEMDATA,
    input  logic [31:0] iDregDATA,
    input  logic [4:0]  iDregADDR,
    input  logic [4:0]  iDecodedOP,
    input  logic [1:0]  iINVALID,
    output logic        oBUSREQ,
    output logic        oBUSWE,
    output logic [29:0] oBUSADDR,
    output logic [31:0] oBUSWDATA,
    output logic [3:0]  oBUSBE,
    input  logic [31:0] iBUSRDATA,
    input  logic        iBUSACK,
    output logic [31:0] oDregDATA,
    output logic [4:0]  oDregADDR,
    output logic        oWBVALID,
    output logic        oSTALL,
    output logic [3:0]  oINVALID
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q;

    logic        busreq_q;
    logic        buswe_q;
    logic [29:0] busaddr_q;
    logic [31:0] buswdata_q;
    logic [3:0]  busbe_q;
    logic [31:0] dreg_data_q;
    logic [4:0]  dreg_addr_q;
    logic        wbvalid_q;
    logic        stall_q;
    logic [3:0]  inv_q;

    // Per-access context kept while the bus cycle is outstanding
    logic        rw_q;
    logic [4:0]  op_q;
    logic [1:0]  off_q;
    logic [1:0]  pinv_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    logic        is_h;
    logic        is_w;
    logic        misalign;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_d;

    always_comb begin
        is_h     = iDecodedOP[1] | iDecodedOP[4];
        is_w     = iDecodedOP[2];
        misalign = (is_h & iMEMADDR[0]) | (is_w & (|iMEMADDR[1:0]));

        if (is_w) begin
            be_d    = 4'b1111;
            wdata_d = iMEMDATA;
        end else if (is_h) begin
            be_d    = 4'b0011 << iMEMADDR[1:0];
            wdata_d = {2{iMEMDATA[15:0]}};
        end else begin
            be_d    = 4'b0001 << iMEMADDR[1:0];
            wdata_d = {4{iMEMDATA[7:0]}};
        end
    end

    // Shift the addressed lane down to bit 0, then extend by access size
    always_comb begin
        lane = iBUSRDATA >> {off_q, 3'b000};
        if (op_q[0]) begin
            load_d = {{24{lane[7]}}, lane[7:0]};
        end else if (op_q[1]) begin
            load_d = {{16{lane[15]}}, lane[15:0]};
        end else if (op_q[3]) begin
            load_d = {24'h0, lane[7:0]};
        end else if (op_q[4]) begin
            load_d = {16'h0, lane[15:0]};
        end else begin
            load_d = iBUSRDATA;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            busreq_q    <= 1'b0;
            buswe_q     <= 1'b0;
            busaddr_q   <= '0;
            buswdata_q  <= '0;
            busbe_q     <= '0;
            dreg_data_q <= '0;
            dreg_addr_q <= '0;
            wbvalid_q   <= 1'b0;
            stall_q     <= 1'b0;
            inv_q       <= '0;
            rw_q        <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
            pinv_q      <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            wbvalid_q <= 1'b0;
            inv_q     <= '0;
            case (state_q)
                IDLE: begin
                    dreg_addr_q <= iDregADDR;
                    if (!iMEM) begin
                        dreg_data_q <= iDregDATA;
                        wbvalid_q   <= (iDregADDR != 5'd0);
                        inv_q       <= {2'b00, iINVALID};
                    end else if (misalign) begin
                        dreg_data_q <= '0;
                        inv_q       <= {2'b01, iINVALID};
                    end else begin
                        state_q     <= BUSY;
                        stall_q     <= 1'b1;
                        busreq_q    <= 1'b1;
                        buswe_q     <= ~iRW;
                        busaddr_q   <= iMEMADDR[31:2];
                        busbe_q     <= be_d;
                        buswdata_q  <= wdata_d;
                        dreg_data_q <= '0;
                        rw_q        <= iRW;
                        op_q        <= iDecodedOP;
                        off_q       <= iMEMADDR[1:0];
                        pinv_q      <= iINVALID;
`ifdef MEM_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (iBUSACK) begin
                        state_q    <= IDLE;
                        stall_q    <= 1'b0;
                        busreq_q   <= 1'b0;
                        buswe_q    <= 1'b0;
                        busaddr_q  <= '0;
                        buswdata_q <= '0;
                        busbe_q    <= '0;
                        inv_q      <= {2'b00, pinv_q};
                        if (rw_q) begin
                            dreg_data_q <= load_d;
                            wbvalid_q   <= (dreg_addr_q != 5'd0);
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Counter would reach the limit on this edge: abandon the access
                        state_q    <= IDLE;
                        stall_q    <= 1'b0;
                        busreq_q   <= 1'b0;
                        buswe_q    <= 1'b0;
                        busaddr_q  <= '0;
                        buswdata_q <= '0;
                        busbe_q    <= '0;
                        inv_q      <= {2'b10, pinv_q};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oBUSREQ   = busreq_q;
    assign oBUSWE    = buswe_q;
    assign oBUSADDR  = busaddr_q;
    assign oBUSWDATA = buswdata_q;
    assign oBUSBE    = busbe_q;
    assign oDregDATA = dreg_data_q;
    assign oDregADDR = dreg_addr_q;
    assign oWBVALID  = wbvalid_q;
    assign oSTALL    = stall_q;
    assign oINVALID  = inv_q;

endmodule

// File: tb/tb_mem_stage_rv32.sv
// Scoreboard bench for mem_stage_rv32: expected result cycles are queued at issue and
// popped whenever the DUT reports a writeback or an exception.
module tb_mem_stage_rv32;

    localparam logic [4:0] OP_B  = 5'b00001;
    localparam logic [4:0] OP_H  = 5'b00010;
    localparam logic [4:0] OP_W  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_HU = 5'b10000;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iRW;
    logic        iMEM;
    logic [31:0] iMEMADDR;
    logic [31:0] iMEMDATA;
    logic [31:0] iDregDATA;
    logic [4:0]  iDregADDR;
    logic [4:0]  iDecodedOP;
    logic [1:0]  iINVALID;
    logic        oBUSREQ;
    logic        oBUSWE;
    logic [29:0] oBUSADDR;
    logic [31:0] oBUSWDATA;
    logic [3:0]  oBUSBE;
    logic [31:0] iBUSRDATA;
    logic        iBUSACK;
    logic [31:0] oDregDATA;
    logic [4:0]  oDregADDR;
    logic        oWBVALID;
    logic        oSTALL;
    logic [3:0]  oINVALID;

    mem_stage_rv32 dut (
        .iCLK(iCLK), .iRST(iRST), .iRW(iRW), .iMEM(iMEM),
        .iMEMADDR(iMEMADDR), .iMEMDATA(iMEMDATA),
        .iDregDATA(iDregDATA), .iDregADDR(iDregADDR),
        .iDecodedOP(iDecodedOP), .iINVALID(iINVALID),
        .oBUSREQ(oBUSREQ), .oBUSWE(oBUSWE), .oBUSADDR(oBUSADDR),
        .oBUSWDATA(oBUSWDATA), .oBUSBE(oBUSBE),
        .iBUSRDATA(iBUSRDATA), .iBUSACK(iBUSACK),
        .oDregDATA(oDregDATA), .oDregADDR(oDregADDR),
        .oWBVALID(oWBVALID), .oSTALL(oSTALL), .oINVALID(oINVALID)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        wb;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  inv;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic wb, input logic [31:0] data, input logic [4:0] rd,
                        input logic [3:0] inv);
        exp_t x;
        x.wb = wb; x.data = data; x.rd = rd; x.inv = inv;
        sb.push_back(x);
    endtask

    // One clock; sample 1 time unit after the edge and retire any reported result
    task automatic cyc();
        @(posedge iCLK);
        #1;
        if (oWBVALID || oINVALID != 4'd0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result wb=%0b data=%h rd=%0d inv=%b",
                         oWBVALID, oDregDATA, oDregADDR, oINVALID);
            end else begin
                e = sb.pop_front();
                if (oWBVALID !== e.wb || oINVALID !== e.inv ||
                    (e.wb && (oDregDATA !== e.data || oDregADDR !== e.rd))) begin
                    errors++;
                    $display("FAIL result got wb=%0b data=%h rd=%0d inv=%b want wb=%0b data=%h rd=%0d inv=%b",
                             oWBVALID, oDregDATA, oDregADDR, oINVALID, e.wb, e.data, e.rd, e.inv);
                end
            end
        end
    endtask

    task automatic set_idle();
        iMEM = 1'b0; iRW = 1'b0; iMEMADDR = '0; iMEMDATA = '0;
        iDregDATA = '0; iDregADDR = '0; iDecodedOP = '0; iINVALID = '0;
    endtask

    task automatic accept(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic [4:0] op, input logic [1:0] inv);
        iMEM = 1'b1; iRW = rw; iMEMADDR = addr; iMEMDATA = data;
        iDregADDR = rd; iDecodedOP = op; iINVALID = inv; iDregDATA = 32'h5A5A5A5A;
        cyc();
        set_idle();
    endtask

    // Wait states then one ack cycle; returns number of sampled cycles with oSTALL high
    task automatic serve(input int waits, input logic [31:0] rdata, output int stall_cnt);
        stall_cnt = int'(oSTALL);
        for (int i = 0; i < waits; i++) begin
            cyc();
            stall_cnt += int'(oSTALL);
        end
        iBUSACK = 1'b1; iBUSRDATA = rdata;
        cyc();
        iBUSACK = 1'b0; iBUSRDATA = '0;
        stall_cnt += int'(oSTALL);
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        set_idle();
        iBUSACK = 1'b0; iBUSRDATA = '0;
        cyc(); cyc();
        checks++;
        if ({oBUSREQ, oBUSWE, oBUSADDR, oBUSWDATA, oBUSBE, oDregDATA, oDregADDR,
             oWBVALID, oSTALL, oINVALID} !== '0) begin
            errors++;
            $display("FAIL reset_outputs req=%0b we=%0b be=%b wb=%0b stall=%0b inv=%b",
                     oBUSREQ, oBUSWE, oBUSBE, oWBVALID, oSTALL, oINVALID);
        end
        iRST = 1'b0;
        cyc();
    endtask

    task automatic test_load_word();
        int st;
        push(1'b1, 32'hDEADBEEF, 5'd5, 4'b0000);
        accept(1'b1, 32'h100, 32'h0, 5'd5, OP_W, 2'b00);
        checks++;
        if (oBUSREQ !== 1'b1 || oBUSWE !== 1'b0 || oBUSADDR !== 30'h40 || oBUSBE !== 4'b1111) begin
            errors++;
            $display("FAIL lw_request req=%0b we=%0b addr=%h be=%b want 1 0 40 1111",
                     oBUSREQ, oBUSWE, oBUSADDR, oBUSBE);
        end
        st = int'(oSTALL);
        for (int i = 0; i < 3; i++) begin
            cyc();
            st += int'(oSTALL);
            checks++;
            if (oBUSREQ !== 1'b1 || oBUSADDR !== 30'h40 || oBUSBE !== 4'b1111) begin
                errors++;
                $display("FAIL lw_bus_stable cycle=%0d req=%0b addr=%h be=%b", i, oBUSREQ, oBUSADDR, oBUSBE);
            end
        end
        iBUSACK = 1'b1; iBUSRDATA = 32'hDEADBEEF;
        cyc();
        iBUSACK = 1'b0;
        st += int'(oSTALL);
        checks++;
        if (st !== 4 || oBUSREQ !== 1'b0) begin
            errors++;
            $display("FAIL lw_stall_cycles got=%0d req=%0b want 4 0", st, oBUSREQ);
        end
        cyc();
        checks++;
        if (sb.size() != 0 || oWBVALID !== 1'b0) begin
            errors++;
            $display("FAIL lw_writeback pending=%0d wb=%0b want 0 0", sb.size(), oWBVALID);
        end
    endtask

    task automatic test_load_sub();
        logic [31:0] addr_t  [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
        logic [4:0]  op_t    [5] = '{OP_B, OP_BU, OP_H, OP_HU, OP_B};
        logic [31:0] rdata_t [5] = '{32'h80123456, 32'h80123456, 32'h80015555, 32'h1234F00D, 32'h00007F00};
        logic [31:0] exp_t_  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F};
        logic [3:0]  be_t    [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
        int st;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, exp_t_[i], 5'(7 + i), 4'b0000);
            accept(1'b1, addr_t[i], 32'h0, 5'(7 + i), op_t[i], 2'b00);
            checks++;
            if (oBUSBE !== be_t[i] || oBUSADDR !== addr_t[i][31:2] || oBUSWE !== 1'b0) begin
                errors++;
                $display("FAIL load_sub_request idx=%0d be=%b addr=%h want be=%b", i, oBUSBE, oBUSADDR, be_t[i]);
            end
            serve(i % 2, rdata_t[i], st);
            checks++;
            if (st !== (i % 2) + 1) begin
                errors++;
                $display("FAIL load_sub_stall idx=%0d got=%0d want=%0d", i, st, (i % 2) + 1);
            end
        end
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL load_sub_missing pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_store();
        logic [31:0] addr_t [3] = '{32'h202, 32'h201, 32'h300};
        logic [31:0] data_t [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
        logic [4:0]  op_t   [3] = '{OP_H, OP_B, OP_W};
        logic [31:0] wd_t   [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
        logic [3:0]  be_t   [3] = '{4'b1100, 4'b0010, 4'b1111};
        int st;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) push(1'b0, 32'h0, 5'd0, 4'b0011);
            accept(1'b0, addr_t[i], data_t[i], 5'd5, op_t[i], (i == 2) ? 2'b11 : 2'b00);
            checks++;
            if (oBUSREQ !== 1'b1 || oBUSWE !== 1'b1 || oBUSBE !== be_t[i] ||
                oBUSWDATA !== wd_t[i] || oBUSADDR !== addr_t[i][31:2]) begin
                errors++;
                $display("FAIL store_request idx=%0d we=%0b be=%b wdata=%h addr=%h want be=%b wdata=%h",
                         i, oBUSWE, oBUSBE, oBUSWDATA, oBUSADDR, be_t[i], wd_t[i]);
            end
            serve(1, 32'hFFFFFFFF, st);
            checks++;
            if (oWBVALID !== 1'b0 || oBUSREQ !== 1'b0) begin
                errors++;
                $display("FAIL store_no_wb idx=%0d wb=%0b req=%0b want 0 0", i, oWBVALID, oBUSREQ);
            end
        end
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL store_missing pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_misaligned();
        push(1'b0, 32'h0, 5'd0, 4'b0100);
        accept(1'b1, 32'h101, 32'h0, 5'd4, OP_W, 2'b00);
        checks++;
        if (oBUSREQ !== 1'b0 || oSTALL !== 1'b0 || oWBVALID !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_lw req=%0b stall=%0b wb=%0b want 0 0 0", oBUSREQ, oSTALL, oWBVALID);
        end
        push(1'b0, 32'h0, 5'd0, 4'b0101);
        accept(1'b0, 32'h203, 32'h1111, 5'd0, OP_HU, 2'b01);
        checks++;
        if (oBUSREQ !== 1'b0 || oSTALL !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_sh req=%0b stall=%0b want 0 0", oBUSREQ, oSTALL);
        end
        cyc();
        checks++;
        if (sb.size() != 0 || oBUSREQ !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_missing pending=%0d req=%0b want 0 0", sb.size(), oBUSREQ);
        end
    endtask

    task automatic test_passthrough();
        iDregDATA = 32'h7; iDregADDR = 5'd0;
        cyc();
        checks++;
        if (oWBVALID !== 1'b0) begin
            errors++;
            $display("FAIL pass_rd0 wb=%0b want 0", oWBVALID);
        end
        push(1'b1, 32'h7, 5'd3, 4'b0000);
        iDregADDR = 5'd3;
        cyc();
        push(1'b0, 32'h0, 5'd0, 4'b0010);
        iDregADDR = 5'd0; iINVALID = 2'b10;
        cyc();
        set_idle();
        cyc();
        checks++;
        if (sb.size() != 0 || oWBVALID !== 1'b0 || oINVALID !== 4'd0) begin
            errors++;
            $display("FAIL pass_single pending=%0d wb=%0b inv=%b want 0 0 0000", sb.size(), oWBVALID, oINVALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int st;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            push(1'b1, d, 5'(i + 1), 4'b0000);
            iDregDATA = d; iDregADDR = 5'(i + 1);
            cyc();
        end
        push(1'b1, 32'h0BADF00D, 5'd31, 4'b0001);
        accept(1'b1, 32'h40, 32'h0, 5'd31, OP_W, 2'b01);
        serve(0, 32'h0BADF00D, st);
        d = $urandom;
        push(1'b1, d, 5'd2, 4'b0000);
        iDregDATA = d; iDregADDR = 5'd2;
        cyc();
        set_idle();
        cyc();
        checks++;
        if (sb.size() != 0 || st !== 1) begin
            errors++;
            $display("FAIL back_to_back pending=%0d stall=%0d want 0 1", sb.size(), st);
        end
    endtask

    task automatic test_stall_ignore();
        push(1'b1, 32'h11223344, 5'd8, 4'b0000);
        accept(1'b1, 32'h10, 32'h0, 5'd8, OP_W, 2'b00);
        iMEM = 1'b1; iRW = 1'b0; iMEMADDR = 32'h999; iDecodedOP = OP_B; iDregADDR = 5'd9;
        cyc(); cyc();
        checks++;
        if (oBUSADDR !== 30'h4 || oBUSWE !== 1'b0 || oBUSREQ !== 1'b1 || oSTALL !== 1'b1) begin
            errors++;
            $display("FAIL stall_ignore addr=%h we=%0b req=%0b stall=%0b want 4 0 1 1",
                     oBUSADDR, oBUSWE, oBUSREQ, oSTALL);
        end
        set_idle();
        iBUSACK = 1'b1; iBUSRDATA = 32'h11223344;
        cyc();
        iBUSACK = 1'b0;
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_ignore_missing pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        accept(1'b1, 32'h80, 32'h0, 5'd10, OP_W, 2'b00);
        cyc();
        iRST = 1'b1;
        cyc();
        checks++;
        if (oBUSREQ !== 1'b0 || oSTALL !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid req=%0b stall=%0b want 0 0", oBUSREQ, oSTALL);
        end
        iRST = 1'b0;
        iBUSACK = 1'b1; iBUSRDATA = 32'hFEEDFACE;
        cyc();
        iBUSACK = 1'b0;
        cyc();
        checks++;
        if (oWBVALID !== 1'b0 || oBUSREQ !== 1'b0 || oSTALL !== 1'b0) begin
            errors++;
            $display("FAIL late_ack wb=%0b req=%0b stall=%0b want 0 0 0", oWBVALID, oBUSREQ, oSTALL);
        end
    endtask

    task automatic test_timeout();
        int n;
        int st;
`ifdef MEM_TIMEOUT_EN
        push(1'b0, 32'h0, 5'd0, 4'b1000);
        accept(1'b1, 32'h44, 32'h0, 5'd11, OP_W, 2'b00);
        n = int'(oBUSREQ);
        for (int i = 0; i < 200 && oBUSREQ; i++) begin
            cyc();
            n += int'(oBUSREQ);
        end
        cyc();
        checks++;
        if (n !== 64 || sb.size() != 0 || oSTALL !== 1'b0) begin
            errors++;
            $display("FAIL timeout req_cycles=%0d pending=%0d stall=%0b want 64 0 0", n, sb.size(), oSTALL);
        end
`else
        push(1'b1, 32'h00C0FFEE, 5'd11, 4'b0000);
        accept(1'b1, 32'h44, 32'h0, 5'd11, OP_W, 2'b00);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n += int'(oBUSREQ & oSTALL);
        end
        serve(0, 32'h00C0FFEE, st);
        cyc();
        checks++;
        if (n !== 100 || sb.size() != 0 || oINVALID !== 4'd0) begin
            errors++;
            $display("FAIL no_timeout busy_cycles=%0d pending=%0d inv=%b want 100 0 0000", n, sb.size(), oINVALID);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misaligned();
        test_passthrough();
        test_back_to_back();
        test_stall_ignore();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
